// File: rtl/variable_pkg.sv
// Shared game constants and types used by the power-bar logic.
package variable_pkg;

    localparam logic [1:0] PLAYER_1 = 2'b01;
    localparam logic [1:0] PLAYER_2 = 2'b10;

    // Top of the power range; must fit in 5 bits.
    localparam int unsigned MAX_POWER = 31;
    // 25 ms per power step at 60 MHz.
    localparam int unsigned POWER_TICK_CYCLES = 1_500_000;

    typedef enum logic [1:0] {
        IDLE,
        CHARGE,
        FLIGHT
    } power_state_t;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } power_dir_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_CYCLES cycles; clear holds it at zero.
module tick_gen #(
    parameter int unsigned TICK_CYCLES = variable_pkg::POWER_TICK_CYCLES
) (
    input  logic clk60MHz,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Tick on the last count, then wrap; clear forces the count back to zero.
    always_comb begin
        tick    = !clear && (count_q == LAST);
        count_d = count_q + 1'b1;
        if (clear || tick) begin
            count_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/power_control.sv
// Shot-strength charger: holding the shoot key bounces power between 0 and
// MAX_POWER; release latches it and strobes fire, then the bar holds until
// the projectile is done.
module power_control #(
    parameter int unsigned TICK_CYCLES = variable_pkg::POWER_TICK_CYCLES,
    parameter int unsigned MAX_POWER   = variable_pkg::MAX_POWER
) (
    input  logic       clk60MHz,
    input  logic       rst,
    input  logic       key_shoot,
    input  logic [1:0] current_player,
    input  logic [1:0] local_player,
    input  logic       projectile_done,
    output logic [4:0] power,
    output logic [4:0] shot_power,
    output logic       fire,
    output logic       busy
);

    import variable_pkg::*;

    localparam logic [4:0] MAX_P = 5'(MAX_POWER);

    power_state_t state_q, state_d;
    power_dir_t   dir_q, dir_d;
    logic [4:0]   power_q, power_d;
    logic [4:0]   shot_power_q, shot_power_d;
    logic         fire_q, fire_d;
    logic         busy_q, busy_d;
    logic         key_prev_q;
    logic         my_turn;
    logic         key_rise;
    logic         tick;
    logic         tick_clear;

    // Prescaler only runs while charging, so it restarts from zero on every entry.
    assign tick_clear = (state_q != CHARGE);

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clk60MHz(clk60MHz),
        .rst     (rst),
        .clear   (tick_clear),
        .tick    (tick)
    );

    // Next-state, bounce stepping and fire strobe.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        power_d      = power_q;
        shot_power_d = shot_power_q;
        fire_d       = 1'b0;
        my_turn      = (current_player == local_player);
        key_rise     = key_shoot && !key_prev_q;

        case (state_q)
            IDLE: begin
                if (key_rise && my_turn) begin
                    state_d = CHARGE;
                    dir_d   = DIR_UP;
                    power_d = '0;
                end
            end
            CHARGE: begin
                // Priority: turn loss aborts, then release fires, then tick steps.
                if (!my_turn) begin
                    state_d = IDLE;
                    power_d = '0;
                end else if (!key_shoot) begin
                    state_d      = FLIGHT;
                    shot_power_d = power_q;
                    fire_d       = 1'b1;
                end else if (tick) begin
                    if (dir_q == DIR_UP) begin
                        if (power_q >= MAX_P) begin
                            power_d = MAX_P - 5'd1;
                            dir_d   = DIR_DOWN;
                        end else begin
                            power_d = power_q + 5'd1;
                        end
                    end else begin
                        if (power_q == '0) begin
                            power_d = 5'd1;
                            dir_d   = DIR_UP;
                        end else begin
                            power_d = power_q - 5'd1;
                        end
                    end
                end
            end
            FLIGHT: begin
                if (projectile_done) begin
                    state_d = IDLE;
                    power_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                power_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            state_q      <= IDLE;
            dir_q        <= DIR_UP;
            power_q      <= '0;
            shot_power_q <= '0;
            fire_q       <= 1'b0;
            busy_q       <= 1'b0;
            key_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            power_q      <= power_d;
            shot_power_q <= shot_power_d;
            fire_q       <= fire_d;
            busy_q       <= busy_d;
            key_prev_q   <= key_shoot;
        end
    end

    assign power      = power_q;
    assign shot_power = shot_power_q;
    assign fire       = fire_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_power_control.sv
// Bench for power_control: directed stimulus pushes expected fire results to a
// queue; a monitor pops and compares whenever fire is presented.
module tb_power_control;

    import variable_pkg::*;

    logic       clk60MHz;
    logic       rst;
    logic       key_shoot;
    logic [1:0] current_player;
    logic [1:0] local_player;
    logic       projectile_done;
    logic [4:0] power;
    logic [4:0] shot_power;
    logic       fire;
    logic       busy;

    typedef struct {
        int shot;
        int pwr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic fire_prev = 1'b0;

    power_control #(
        .TICK_CYCLES(4),
        .MAX_POWER  (31)
    ) dut (
        .clk60MHz       (clk60MHz),
        .rst            (rst),
        .key_shoot      (key_shoot),
        .current_player (current_player),
        .local_player   (local_player),
        .projectile_done(projectile_done),
        .power          (power),
        .shot_power     (shot_power),
        .fire           (fire),
        .busy           (busy)
    );

    initial clk60MHz = 1'b0;
    always #5 clk60MHz = ~clk60MHz;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk60MHz);
            #1;
        end
    endtask

    task automatic done_pulse();
        projectile_done = 1'b1;
        step(1);
        projectile_done = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_power"}, int'(power), 0);
        chk({name, "_fire"}, int'(fire), 0);
    endtask

    // Monitor: every fire strobe must match the next queued expectation.
    always @(posedge clk60MHz) begin
        exp_t e;
        #1;
        if (fire) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_fire: got fire=1 expected no fire at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("sb_shot_power", int'(shot_power), e.shot);
                chk("sb_power_at_fire", int'(power), e.pwr);
            end
            if (fire_prev) begin
                n_checks++;
                n_fail++;
                $display("FAIL fire_double: got fire high two cycles expected one at %0t", $time);
            end
        end
        if (power > 5'd31) begin
            n_checks++;
            n_fail++;
            $display("FAIL power_range: got %0d expected <= 31 at %0t", power, $time);
        end
        fire_prev = fire;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish within 100us");
        $fatal(1, "timeout");
    end

    initial begin
        rst             = 1'b1;
        key_shoot       = 1'b0;
        current_player  = PLAYER_1;
        local_player    = PLAYER_1;
        projectile_done = 1'b0;
        step(3);
        chk_idle("reset");
        chk("reset_shot", int'(shot_power), 0);
        rst = 1'b0;
        step(1);

        // 1. Basic shot: 10 ticks then release.
        key_shoot = 1'b1;
        step(1);
        chk("s1_busy_rise", int'(busy), 1);
        chk("s1_power_start", int'(power), 0);
        step(40);
        chk("s1_power10", int'(power), 10);
        key_shoot = 1'b0;
        exp_q.push_back('{shot: 10, pwr: 10});
        step(1);
        chk("s1_fire", int'(fire), 1);
        chk("s1_busy_flight", int'(busy), 1);
        step(3);
        chk("s1_power_hold", int'(power), 10);
        chk("s1_fire_low", int'(fire), 0);
        done_pulse();
        chk("s1_done_power", int'(power), 0);
        chk("s1_done_busy", int'(busy), 0);

        // 2. Bounce across the top.
        key_shoot = 1'b1;
        step(1);
        step(124);
        chk("s2_power31", int'(power), 31);
        step(4);
        chk("s2_power30", int'(power), 30);
        step(32);
        chk("s2_power22", int'(power), 22);
        key_shoot = 1'b0;
        exp_q.push_back('{shot: 22, pwr: 22});
        step(1);
        done_pulse();
        chk("s2_done_busy", int'(busy), 0);

        // 3. Wrong turn, then turn gained with key already held.
        current_player = PLAYER_2;
        key_shoot      = 1'b1;
        step(3);
        chk_idle("s3_wrong_turn");
        current_player = PLAYER_1;
        step(6);
        chk_idle("s3_no_edge");
        key_shoot = 1'b0;
        step(1);

        // 4. Key held through landing needs a fresh press.
        key_shoot = 1'b1;
        step(1);
        step(12);
        chk("s4_power3", int'(power), 3);
        key_shoot = 1'b0;
        exp_q.push_back('{shot: 3, pwr: 3});
        step(1);
        key_shoot = 1'b1;
        step(5);
        chk("s4_flight_busy", int'(busy), 1);
        chk("s4_flight_power", int'(power), 3);
        done_pulse();
        chk_idle("s4_landed");
        step(8);
        chk_idle("s4_held_idle");
        key_shoot = 1'b0;
        step(1);
        key_shoot = 1'b1;
        step(1);
        chk("s4_repress_busy", int'(busy), 1);
        step(4);
        chk("s4_repress_power1", int'(power), 1);
        key_shoot = 1'b0;
        exp_q.push_back('{shot: 1, pwr: 1});
        step(1);
        done_pulse();

        // 5a. Release coinciding with a tick at power 5.
        key_shoot = 1'b1;
        step(1);
        step(20);
        chk("s5_power5", int'(power), 5);
        step(3);
        key_shoot = 1'b0;
        exp_q.push_back('{shot: 5, pwr: 5});
        step(1);
        chk("s5_release_tick_power", int'(power), 5);
        done_pulse();

        // 5b. Turn lost while charging at power 7.
        key_shoot = 1'b1;
        step(1);
        step(28);
        chk("s5_power7", int'(power), 7);
        current_player = PLAYER_2;
        step(1);
        chk_idle("s5_turn_lost");
        current_player = PLAYER_1;
        key_shoot      = 1'b0;
        step(2);

        // 5c. Turn loss and release together: abort wins.
        key_shoot = 1'b1;
        step(1);
        step(8);
        chk("s5_power2", int'(power), 2);
        current_player = PLAYER_2;
        key_shoot      = 1'b0;
        step(1);
        chk_idle("s5_abort_wins");
        current_player = PLAYER_1;
        step(1);

        // 6. Reset mid-charge at power 12.
        key_shoot = 1'b1;
        step(1);
        step(48);
        chk("s6_power12", int'(power), 12);
        rst = 1'b1;
        step(1);
        chk_idle("s6_reset");
        chk("s6_reset_shot", int'(shot_power), 0);
        rst       = 1'b0;
        key_shoot = 1'b0;
        step(1);
        key_shoot = 1'b1;
        step(1);
        chk("s6_recharge_busy", int'(busy), 1);
        chk("s6_recharge_power0", int'(power), 0);
        step(4);
        chk("s6_recharge_power1", int'(power), 1);
        key_shoot = 1'b0;
        exp_q.push_back('{shot: 1, pwr: 1});
        step(1);
        done_pulse();
        step(2);

        chk("sb_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
